// File: rtl/ssp_arbiter.sv
// ssp_arbiter: round-robin grant of whole words from N_REQ byte streams into one shared SSP packer,
// tagging each emitted packer word with the index of the requester that supplied it.
module ssp_arbiter #(
  parameter int N_REQ = 4,
  parameter int BYTES_PER_WORD = 4,
  parameter int TAG_DEPTH = 4,
  parameter int IDW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         pk_din,
  output logic               pk_din_valid,
  input  logic               pk_dout_valid,
  output logic [IDW-1:0]     owner_id,
  output logic               owner_valid,
  output logic               busy,
  output logic               tag_err
);
  localparam int BW = $clog2(BYTES_PER_WORD + 1);
  localparam int TW = $clog2(TAG_DEPTH + 1);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] g, rr, win;
  logic [2*N_REQ-1:0] dbl;
  logic win_ok, grant, accept, last, pop;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] wp, rp;
  logic [IDW-1:0] tags [TAG_DEPTH];

  // rotate requests so rr sits at bit 0; the lowest set bit is the winner
  always_comb begin
    dbl = {req_valid, req_valid} >> rr;
    win = '0;
    win_ok = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (dbl[i]) begin
        win = IDW'((int'(rr) + i) % N_REQ);
        win_ok = 1'b1;
      end
  end

  assign grant = state == IDLE && win_ok && tcnt < TW'(TAG_DEPTH);
  assign accept = state == BURST && |(req_valid & req_ready);
  assign last = accept && bcnt == BW'(BYTES_PER_WORD - 1);
  assign pop = pk_dout_valid && tcnt != '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_comb state_nxt = state == IDLE ? (grant ? BURST : IDLE) : (last ? IDLE : BURST);

  always_comb begin
    req_ready = state == BURST ? N_REQ'(1) << g : '0;
    busy = state == BURST;
    owner_valid = pop;
    owner_id = tags[rp];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      g <= '0;
      rr <= '0;
      bcnt <= '0;
      tcnt <= '0;
      wp <= '0;
      rp <= '0;
      pk_din <= '0;
      pk_din_valid <= 1'b0;
      tag_err <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tags[i] <= '0;
    end else begin
      if (grant) begin
        g <= win;
        bcnt <= '0;
        tags[wp] <= win;
        wp <= wp == PW'(TAG_DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (accept) begin
        bcnt <= bcnt + 1'b1;
        pk_din <= 8'(req_data >> {g, 3'b000});
      end
      if (last) rr <= g == IDW'(N_REQ - 1) ? '0 : g + 1'b1;
      pk_din_valid <= accept;
      if (pop) rp <= rp == PW'(TAG_DEPTH - 1) ? '0 : rp + 1'b1;
      tcnt <= tcnt + TW'(grant) - TW'(pop);
      if (pk_dout_valid && tcnt == '0) tag_err <= 1'b1;
    end
endmodule

// File: tb/tb_ssp_arbiter.sv
// tb_ssp_arbiter: directed scenarios plus random traffic checked against a queue-based reference model
module tb_ssp_arbiter;
  localparam int N = 4, BPW = 4, TD = 2, IDW = 3;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] pk_din;
  logic pk_din_valid, pk_dout_valid = 0, owner_valid, busy, tag_err;
  logic [IDW-1:0] owner_id;
  int vectors = 0, miscompares = 0;
  bit m_burst, m_dv, m_err;
  int m_g, m_rr, m_cnt;
  int tagq[$];
  logic [7:0] m_din;
  byte unsigned src[N][$];
  bit hold[N];
  bit pk_en = 1, spur = 0;
  int pk_cnt = 0, pk_pend = 0;
  int grants[$], owners[$];
  logic [N-1:0] prev_ready = '0;

  always #5 clk = ~clk;

  ssp_arbiter #(.N_REQ(N), .BYTES_PER_WORD(BPW), .TAG_DEPTH(TD), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pk_din(pk_din), .pk_din_valid(pk_din_valid), .pk_dout_valid(pk_dout_valid),
    .owner_id(owner_id), .owner_valid(owner_valid), .busy(busy), .tag_err(tag_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1;
    req_valid = '0;
    pk_dout_valid = 0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_pk_din", pk_din, 0);
    check("rst_pk_din_valid", pk_din_valid, 0);
    check("rst_owner_valid", owner_valid, 0);
    check("rst_owner_id", owner_id, 0);
    check("rst_busy", busy, 0);
    check("rst_tag_err", tag_err, 0);
    m_burst = 0; m_dv = 0; m_err = 0; m_g = 0; m_rr = 0; m_cnt = 0; m_din = 0;
    tagq.delete();
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      hold[i] = 0;
    end
    pk_cnt = 0; pk_pend = 0; pk_en = 1; spur = 0; prev_ready = '0;
    grants.delete();
    owners.delete();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic cycle();
    logic [N-1:0] rdy;
    bit dv, pulse, acc, pop, room;
    int w;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = src[i].size() > 0 && !hold[i];
      req_data[8*i +: 8] = src[i].size() > 0 ? src[i][0] : 8'($urandom);
    end
    pulse = pk_en && pk_pend > 0;
    pk_dout_valid = pulse || spur;
    #1;
    rdy = req_ready;
    dv = pk_din_valid;
    check("req_ready", rdy, m_burst ? 32'(1) << m_g : 32'(0));
    check("busy", busy, m_burst);
    check("pk_din_valid", dv, m_dv);
    check("pk_din", pk_din, m_din);
    check("owner_valid", owner_valid, pk_dout_valid && tagq.size() > 0);
    if (pk_dout_valid && tagq.size() > 0) check("owner_id", owner_id, tagq[0]);
    check("tag_err", tag_err, m_err);
    if (owner_valid) owners.push_back(int'(owner_id));
    if (rdy != 0 && prev_ready == 0) grants.push_back($clog2(rdy));
    prev_ready = rdy;
    @(posedge clk);
    acc = m_burst && req_valid[m_g];
    pop = pk_dout_valid && tagq.size() > 0;
    room = tagq.size() < TD;
    if (pk_dout_valid && tagq.size() == 0) m_err = 1;
    m_dv = acc;
    if (acc) m_din = req_data[8*m_g +: 8];
    if (pop) void'(tagq.pop_front());
    if (!m_burst) begin
      if (req_valid != 0 && room) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        m_g = w; m_cnt = 0; m_burst = 1;
        tagq.push_back(w);
      end
    end else if (acc) begin
      m_cnt++;
      if (m_cnt == BPW) begin
        m_burst = 0;
        m_rr = (m_g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++)
      if (rdy[i] && req_valid[i]) void'(src[i].pop_front());
    if (pulse) pk_pend--;
    if (dv) begin
      pk_cnt++;
      if (pk_cnt == BPW) begin
        pk_cnt = 0;
        pk_pend++;
      end
    end
  endtask

  initial begin
    do_reset();
    src[2] = {8'h94, 8'h0F, 8'h51, 8'h24};
    repeat (8) cycle();
    check("single_owner_cnt", owners.size(), 1);
    check("single_owner", owners[0], 2);
    src[0] = {8'h01, 8'h02, 8'h03, 8'h04};
    src[3] = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    repeat (16) cycle();
    check("rr_grant_cnt", grants.size(), 3);
    check("rr_next_is_3", grants[1], 3);
    check("rr_then_0", grants[2], 0);
    do_reset();
    for (int i = 0; i < N; i++)
      repeat (3 * BPW) src[i].push_back(8'($urandom));
    repeat (80) cycle();
    check("fair_grant_cnt", grants.size(), 12);
    check("fair_owner_cnt", owners.size(), 12);
    for (int k = 0; k < 12; k++) begin
      check("fair_grant", grants[k], k % N);
      check("fair_owner", owners[k], k % N);
    end
    do_reset();
    src[1] = {8'h67, 8'hF3, 8'h11, 8'h22};
    repeat (2) cycle();
    hold[1] = 1;
    repeat (3) cycle();
    hold[1] = 0;
    repeat (8) cycle();
    check("gap_grant_cnt", grants.size(), 1);
    check("gap_owner_cnt", owners.size(), 1);
    check("gap_owner", owners[0], 1);
    do_reset();
    pk_en = 0;
    for (int i = 0; i < 3; i++)
      repeat (BPW) src[i].push_back(8'($urandom));
    repeat (20) cycle();
    check("full_stalled_grants", grants.size(), 2);
    pk_en = 1;
    repeat (20) cycle();
    check("full_grants", grants.size(), 3);
    check("full_third", grants[2], 2);
    check("full_owner_cnt", owners.size(), 3);
    spur = 1;
    cycle();
    spur = 0;
    repeat (4) cycle();
    check("tag_err_sticky", tag_err, 1);
    do_reset();
    src[3] = {8'h31, 8'h32, 8'h33, 8'h34};
    repeat (3) cycle();
    do_reset();
    src[0] = {8'h41, 8'h42, 8'h43, 8'h44};
    src[3] = {8'h51, 8'h52, 8'h53, 8'h54};
    repeat (8) cycle();
    check("post_rst_first_grant", grants[0], 0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src[i].size() == 0 && $urandom_range(3) == 0)
          repeat ($urandom_range(1, 6)) src[i].push_back(8'($urandom));
        hold[i] = $urandom_range(4) == 0;
      end
      pk_en = $urandom_range(3) != 0;
      spur = $urandom_range(150) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time bound");
    $fatal(1);
  end
endmodule

// File: doc/ssp_arbiter.md
# ssp_arbiter

Round-robin arbiter that shares one SSP byte-to-word packer (8-bit `din`/`din_valid` in, 32-bit `dout`/`dout_valid` out) among `N_REQ` byte-stream requesters. It grants one requester for a whole word, so packed words never mix bytes from different sources. It registers the selected byte into the packer. It tags each word the packer emits with the index of the requester that supplied it. It sits between the CNN feature-fetch channels and the shared SSP instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BYTES_PER_WORD`, 4: bytes per packed word. Must match the packer.
- `TAG_DEPTH`, 4: owner-tag FIFO depth (words in flight inside the packer), 2..8.
- `IDW`, 3: owner-index width. Must satisfy 2^`IDW` ≥ `N_REQ`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `N_REQ`  per-requester byte valid.
- `req_data`  in  8·`N_REQ`  byte of requester i at bits [8i+7:8i].
- `req_ready`  out  `N_REQ`  per-requester accept, one-hot or zero.
- `pk_din`  out  8  byte to the packer `din`.
- `pk_din_valid`  out  1  to the packer `din_valid`.
- `pk_dout_valid`  in  1  from the packer `dout_valid`.
- `owner_id`  out  `IDW`  requester index of the word currently on the packer `dout`.
- `owner_valid`  out  1  qualifies `owner_id`.
- `busy`  out  1  high when state is BURST.
- `tag_err`  out  1  sticky error flag.

## Operation
- Two-state FSM: IDLE and BURST. Registers: grant index `g`, round-robin pointer `rr`, byte counter `bcnt` (0..`BYTES_PER_WORD`-1), tag FIFO with occupancy `tcnt`.
- IDLE:
  - Arbitration runs when `|req_valid` and `tcnt < TAG_DEPTH`, using registered `tcnt`; a pop in the same cycle does not free space.
  - Winner: first asserted `req_valid` found scanning from `rr` upward, wrapping modulo `N_REQ`.
  - On a win: `g` ← winner, winner index pushed to the tag FIFO, `bcnt` ← 0, next state BURST.
  - `req_ready` = 0 in IDLE.
- BURST:
  - `req_ready[g]` = 1 regardless of `req_valid`; all other `req_ready` bits = 0.
  - A byte is accepted when `req_valid[g] & req_ready[g]`. Each accept increments `bcnt`.
  - If the granted requester drops valid, the grant is held with no timeout. The packer sees `din_valid` gaps, which it tolerates.
  - On the accept with `bcnt == BYTES_PER_WORD-1`: next state IDLE, `rr` ← (`g`+1) mod `N_REQ`.
- Packer drive (registered):
  - On an accepted byte: `pk_din` ← `req_data[g]`, `pk_din_valid` ← 1.
  - Otherwise `pk_din_valid` ← 0 and `pk_din` holds its value.
- Owner tagging (combinational from FIFO head):
  - `owner_id` = head entry.
  - `owner_valid` = `pk_dout_valid & (tcnt != 0)`. When this is 1 the head is popped.
  - `pk_dout_valid` with `tcnt == 0`: `tag_err` ← 1 (sticky until `rst`), nothing is popped, `owner_valid` = 0.
- A push and a pop in the same cycle are both performed and `tcnt` is unchanged. A push never happens at `tcnt == TAG_DEPTH` because the IDLE gate prevents it.
- Pointers wrap modulo `TAG_DEPTH`.

## Timing
- Reset (async assert, state cleared immediately): state IDLE, `g`=0, `rr`=0, `bcnt`=0, FIFO empty, `req_ready`=0, `pk_din`=0, `pk_din_valid`=0, `owner_valid`=0, `owner_id`=0, `busy`=0, `tag_err`=0.
- Reset mid-burst drops the partial word and its tag. The packer must share `rst` so that both blocks restart aligned.
- Grant latency: 1 cycle. Requests seen in IDLE at edge k → BURST with `req_ready` high after edge k.
- Byte latency: accepted at edge k → `pk_din`/`pk_din_valid` valid after edge k, i.e. sampled by the packer at edge k+1.
- Throughput: a burst with continuous valid occupies `BYTES_PER_WORD` cycles in BURST plus 1 IDLE cycle. Peak rate is `BYTES_PER_WORD`/(`BYTES_PER_WORD`+1) bytes per cycle.
- With `TAG_DEPTH` words tagged and none yet emitted, IDLE stalls (`busy`=0, `req_ready`=0) until a pop is registered.

## Test plan
- Single requester: requester 2 sends 0x94, 0x0F, 0x51, 0x24 back-to-back. Required: `req_ready`=4'b0100 for 4 cycles; `pk_din` shows the same sequence one cycle later; on the packer's word, `owner_valid`=1 with `owner_id`=2; `rr`=3.
- Fairness: all 4 requesters hold valid continuously for 3 words each. Grant order must be 0,1,2,3,0,1,2,3,0,1,2,3, and every emitted word's `owner_id` must match the order in which it was granted.
- Mid-burst gap: requester 1 sends 0x67, drops valid for 3 cycles, then sends 0xF3, 0x11, 0x22. Required: grant held throughout, no other `req_ready` bit set, `pk_din_valid` low during the gap, one word tagged 1.
- Tag FIFO full: `TAG_DEPTH`=2, packer output held off, 3 words requested. Required: third grant withheld; it is issued on the cycle after the first `pk_dout_valid` pop.
- Spurious output: pulse `pk_dout_valid` with the FIFO empty. Required: `owner_valid`=0, `tag_err`=1, flag stays set until `rst`.
- Reset mid-burst: assert `rst` after 2 of 4 bytes have been accepted. Required: all outputs return to their reset values immediately; the next burst starts from requester 0 with `bcnt`=0.
